// File: rtl/encoder_pkg.sv
// Shared types and constants for the 16-to-4 streaming encoder.
package encoder_pkg;

  localparam int W  = 16;
  localparam int IW = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Drops the lowest set bit: v & (v - 1).
  function automatic logic [W-1:0] clear_lowest(input logic [W-1:0] v);
    return v & (v - 16'd1);
  endfunction

endpackage

// File: rtl/priority_encoder_16_4.sv
// Combinational lowest-set-bit encoder with an any-set flag.
module priority_encoder_16_4
  import encoder_pkg::*;
(
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan from the top down so the lowest set bit is the one that sticks.
  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      idx_o = vec_i[i] ? IW'(i) : idx_o;
    end
    any_o = |vec_i;
  end

endmodule

// File: rtl/encoder_16_4_stream.sv
// Streams the index of every set bit of an accepted 16-bit vector, lowest first,
// over a valid/ready handshake; all-zero vectors produce a one-cycle zero_vec pulse.
module encoder_16_4_stream
  import encoder_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  vec_in,
  input  logic          vec_valid,
  output logic          vec_ready,
  output logic [IW-1:0] idx_out,
  output logic          idx_valid,
  input  logic          idx_ready,
  output logic          idx_last,
  output logic          zero_vec
);

  state_e          state_q, state_d;
  logic [W-1:0]    pending_q, pending_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            idx_valid_q, idx_valid_d;
  logic            idx_last_q, idx_last_d;
  logic            zero_vec_q, zero_vec_d;

  logic [W-1:0]    enc_in_s;
  logic [W-1:0]    enc_rest_s;
  logic [IW-1:0]   enc_idx_s;
  logic            enc_any_s;

  // One encoder serves both the fresh vector and the remaining pending bits.
  assign enc_in_s   = (state_q == IDLE) ? vec_in : pending_q;
  assign enc_rest_s = clear_lowest(enc_in_s);

  priority_encoder_16_4 u_penc (
    .vec_i (enc_in_s),
    .idx_o (enc_idx_s),
    .any_o (enc_any_s)
  );

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    idx_d       = idx_q;
    idx_valid_d = idx_valid_q;
    idx_last_d  = idx_last_q;
    zero_vec_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (vec_valid) begin
          if (enc_any_s) begin
            state_d     = EMIT;
            idx_d       = enc_idx_s;
            pending_d   = enc_rest_s;
            idx_last_d  = (enc_rest_s == 16'h0000);
            idx_valid_d = 1'b1;
          end else begin
            zero_vec_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (idx_valid_q && idx_ready) begin
          if (idx_last_q) begin
            state_d     = IDLE;
            idx_valid_d = 1'b0;
          end else begin
            idx_d      = enc_idx_s;
            pending_d  = enc_rest_s;
            idx_last_d = (enc_rest_s == 16'h0000);
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d     = IDLE;
        pending_d   = 16'h0000;
        idx_valid_d = 1'b0;
        idx_last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= 16'h0000;
      idx_q       <= 4'd0;
      idx_valid_q <= 1'b0;
      idx_last_q  <= 1'b0;
      zero_vec_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      idx_last_q  <= idx_last_d;
      zero_vec_q  <= zero_vec_d;
    end
  end

  assign vec_ready = (state_q == IDLE);
  assign idx_out   = idx_q;
  assign idx_valid = idx_valid_q;
  assign idx_last  = idx_last_q;
  assign zero_vec  = zero_vec_q;

endmodule

// File: tb/tb_encoder_16_4_stream.sv
// Directed self-checking bench for encoder_16_4_stream.
module tb_encoder_16_4_stream;

  logic        clk;
  logic        rst_n;
  logic [15:0] vec_in;
  logic        vec_valid;
  logic        vec_ready;
  logic [3:0]  idx_out;
  logic        idx_valid;
  logic        idx_ready;
  logic        idx_last;
  logic        zero_vec;

  int n_cmp;
  int n_fail;

  encoder_16_4_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vec_in    (vec_in),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .idx_out   (idx_out),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .idx_last  (idx_last),
    .zero_vec  (zero_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full observation {vec_ready, idx_valid, idx_last, zero_vec, idx_out}.
  logic [7:0] obs;
  assign obs = {vec_ready, idx_valid, idx_last, zero_vec, idx_out};
  // Handshake-side view {vec_ready, idx_valid, zero_vec} for idle checks.
  logic [2:0] obs_idle;
  assign obs_idle = {vec_ready, idx_valid, zero_vec};

  function automatic logic [7:0] mk(input logic rdy, input logic vld, input logic lst,
                                    input logic zv, input logic [3:0] idx);
    return {rdy, vld, lst, zv, idx};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst_n = 1'b0; vec_in = 16'h0000; vec_valid = 1'b0; idx_ready = 1'b0;
    #2;
    e = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, e);
    end
    #10 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_8421();
    logic [3:0] exp_idx [4];
    logic [7:0] e;
    exp_idx[0] = 4'd0; exp_idx[1] = 4'd5; exp_idx[2] = 4'd10; exp_idx[3] = 4'd15;
    vec_in = 16'h8421; vec_valid = 1'b1; idx_ready = 1'b1;
    step();
    vec_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = mk(1'b0, 1'b1, (k == 3), 1'b0, exp_idx[k]);
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL basic_8421[%0d]: got %h expected %h", k, obs, e);
      end
      step();
    end
    n_cmp++;
    if (obs_idle !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_8421_ready_after: got %b expected %b", obs_idle, 3'b100);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e;
    vec_in = 16'h0006; vec_valid = 1'b1; idx_ready = 1'b0;
    step();
    vec_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL stall[%0d]: got %h expected %h", k, obs, e);
      end
      step();
    end
    idx_ready = 1'b1;
    e = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL stall_release_first: got %h expected %h", obs, e);
    end
    step();
    e = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL stall_release_last: got %h expected %h", obs, e);
    end
    step();
    n_cmp++;
    if (obs_idle !== 3'b100) begin
      n_fail++;
      $display("FAIL stall_done_idle: got %b expected %b", obs_idle, 3'b100);
    end
  endtask

  task automatic test_zero_vec();
    vec_in = 16'h0000; vec_valid = 1'b1; idx_ready = 1'b1;
    step();
    vec_valid = 1'b0;
    n_cmp++;
    if (obs_idle !== 3'b101) begin
      n_fail++;
      $display("FAIL zero_pulse: got %b expected %b", obs_idle, 3'b101);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (obs_idle !== 3'b100) begin
        n_fail++;
        $display("FAIL zero_after[%0d]: got %b expected %b", k, obs_idle, 3'b100);
      end
    end
  endtask

  task automatic test_single_bit();
    logic [15:0] vecs [2];
    logic [3:0]  idxs [2];
    logic [7:0]  e;
    vecs[0] = 16'h0001; idxs[0] = 4'd0;
    vecs[1] = 16'h8000; idxs[1] = 4'd15;
    idx_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      vec_in = vecs[k]; vec_valid = 1'b1;
      step();
      vec_valid = 1'b0;
      e = mk(1'b0, 1'b1, 1'b1, 1'b0, idxs[k]);
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL single_bit[%0d]: got %h expected %h", k, obs, e);
      end
      step();
      n_cmp++;
      if (obs_idle !== 3'b100) begin
        n_fail++;
        $display("FAIL single_bit_idle[%0d]: got %b expected %b", k, obs_idle, 3'b100);
      end
    end
  endtask

  // 0xFFFF streams 0..15 while a competing vector is offered and must be ignored.
  task automatic test_full_ignore();
    logic [7:0] e;
    vec_in = 16'hFFFF; vec_valid = 1'b1; idx_ready = 1'b1;
    step();
    vec_in = 16'h00F0;
    for (int k = 0; k < 16; k++) begin
      e = mk(1'b0, 1'b1, (k == 15), 1'b0, 4'(k));
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL full_ffff[%0d]: got %h expected %h", k, obs, e);
      end
      step();
    end
    vec_valid = 1'b0;
    n_cmp++;
    if (obs_idle !== 3'b100) begin
      n_fail++;
      $display("FAIL full_ffff_idle: got %b expected %b", obs_idle, 3'b100);
    end
    step();
  endtask

  task automatic test_reset_mid_emit();
    logic [7:0] e;
    vec_in = 16'hFFFF; vec_valid = 1'b1; idx_ready = 1'b1;
    step();
    vec_in = 16'h00F0;
    for (int k = 0; k < 3; k++) begin
      e = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'(k));
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL pre_reset[%0d]: got %h expected %h", k, obs, e);
      end
      step();
    end
    rst_n = 1'b0;
    #1;
    e = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL mid_emit_reset: got %h expected %h", obs, e);
    end
    vec_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    n_cmp++;
    if (obs_idle !== 3'b100) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b expected %b", obs_idle, 3'b100);
    end
    vec_in = 16'h0010; vec_valid = 1'b1;
    step();
    vec_valid = 1'b0;
    e = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd4);
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL post_reset_0010: got %h expected %h", obs, e);
    end
    step();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic_8421();
    test_backpressure();
    test_zero_vec();
    test_single_bit();
    test_full_ignore();
    test_reset_mid_emit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
